// File: rtl/mem_pkg.sv
// Shared types and defaults for the data-memory responder slice.
package mem_pkg;

  localparam int DEF_DATA_WIDTH    = 20;
  localparam int DEF_ADDRESS_WIDTH = 8;
  localparam int DEF_MEM_SIZE      = 256;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } mem_state_t;

  typedef struct packed {
    logic                         rd;
    logic                         wr;
    logic                         byte_en;
    logic [DEF_ADDRESS_WIDTH-1:0] addr;
    logic [DEF_DATA_WIDTH-1:0]    data;
  } mem_req_t;

  // A request is rejected when it targets a missing word or asks for load and store at once.
  function automatic logic is_rejected(input logic rd, input logic wr, input logic addr_oob);
    return (rd & wr) | addr_oob;
  endfunction

endpackage

// File: rtl/data_mem_array.sv
// Word storage with a synchronous masked write and a combinational read port.
module data_mem_array #(
  parameter int DATA_WIDTH    = 20,
  parameter int ADDRESS_WIDTH = 8,
  parameter int MEM_SIZE      = 256
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic                     byte_mode,
  input  logic [ADDRESS_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  output logic [DATA_WIDTH-1:0]    rdata
);

  localparam logic [DATA_WIDTH-1:0] LOW_BYTE_MASK = DATA_WIDTH'(8'hFF);

  logic [DATA_WIDTH-1:0] mem_r [MEM_SIZE];
  logic [DATA_WIDTH-1:0] lane_mask_s;

  // Byte accesses only touch the low lane; word accesses replace everything.
  always_comb begin
    if (byte_mode) begin
      lane_mask_s = LOW_BYTE_MASK;
    end else begin
      lane_mask_s = '1;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= (mem_r[addr] & ~lane_mask_s) | (wdata & lane_mask_s);
    end
  end

  assign rdata = mem_r[addr];

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding load/store responder with programmable wait states.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int MEM_SIZE      = DEF_MEM_SIZE,
  parameter int WAIT_CYCLES   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     MemRead,
  input  logic                     MemWrite,
  input  logic                     ByteEnable,
  input  logic [ADDRESS_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0]    write_data,
  output logic                     resp_valid,
  output logic [DATA_WIDTH-1:0]    read_data,
  output logic                     resp_err,
  output logic                     busy
);

  localparam int                    CNT_W      = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0]      CNT_LOAD   = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0]      CNT_ONE    = CNT_W'(1);
  localparam bit                    NO_WAIT    = (WAIT_CYCLES == 0);
  localparam logic [ADDRESS_WIDTH:0] ADDR_LIMIT = (ADDRESS_WIDTH + 1)'(MEM_SIZE);

  mem_state_t            state_r;
  logic [CNT_W-1:0]      cnt_r;
  mem_req_t              req_r;
  logic                  req_ready_r;
  logic                  busy_r;
  logic                  resp_valid_r;
  logic                  resp_err_r;
  logic [DATA_WIDTH-1:0] read_data_r;

  mem_req_t              incoming_s;
  mem_req_t              cur_req_s;
  logic                  accept_s;
  logic                  enter_resp_s;
  logic                  oob_s;
  logic                  err_s;
  logic                  commit_we_s;
  logic [DATA_WIDTH-1:0] mem_rdata_s;
  logic [DATA_WIDTH-1:0] resp_data_s;

  // With no wait states the commit happens on the accept edge, so the live inputs are used.
  always_comb begin
    incoming_s = '{rd: MemRead, wr: MemWrite, byte_en: ByteEnable, addr: address, data: write_data};
    if (state_r == IDLE) begin
      cur_req_s = incoming_s;
    end else begin
      cur_req_s = req_r;
    end
  end

  assign accept_s     = req_valid & req_ready_r & (state_r == IDLE);
  assign enter_resp_s = (state_r == IDLE) ? (accept_s & NO_WAIT)
                                          : ((state_r == WAIT) & (cnt_r == CNT_ONE));
  assign oob_s        = ({1'b0, cur_req_s.addr} >= ADDR_LIMIT);
  assign err_s        = is_rejected(cur_req_s.rd, cur_req_s.wr, oob_s);
  assign commit_we_s  = enter_resp_s & cur_req_s.wr & ~err_s;

  // Load result for the commit edge; stores, no-ops and errors return zeros.
  always_comb begin
    resp_data_s = '0;
    if (!err_s && cur_req_s.rd) begin
      if (cur_req_s.byte_en) begin
        resp_data_s = DATA_WIDTH'(mem_rdata_s[7:0]);
      end else begin
        resp_data_s = mem_rdata_s;
      end
    end else begin
      resp_data_s = '0;
    end
  end

  data_mem_array #(
    .DATA_WIDTH    (DATA_WIDTH),
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .MEM_SIZE      (MEM_SIZE)
  ) u_array (
    .clk       (clk),
    .we        (commit_we_s),
    .byte_mode (cur_req_s.byte_en),
    .addr      (cur_req_s.addr),
    .wdata     (cur_req_s.data),
    .rdata     (mem_rdata_s)
  );

  // Request sequencing, commit capture and registered response outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      cnt_r        <= '0;
      req_r        <= '0;
      req_ready_r  <= 1'b0;
      busy_r       <= 1'b0;
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      read_data_r  <= '0;
    end else begin
      resp_valid_r <= 1'b0;
      if (enter_resp_s) begin
        resp_valid_r <= 1'b1;
        resp_err_r   <= err_s;
        read_data_r  <= resp_data_s;
      end
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            req_r       <= incoming_s;
            req_ready_r <= 1'b0;
            busy_r      <= 1'b1;
            cnt_r       <= CNT_LOAD;
            state_r     <= NO_WAIT ? RESP : WAIT;
          end else begin
            req_ready_r <= 1'b1;
            busy_r      <= 1'b0;
          end
        end
        WAIT: begin
          cnt_r <= cnt_r - CNT_ONE;
          if (cnt_r == CNT_ONE) begin
            state_r <= RESP;
          end else begin
            state_r <= WAIT;
          end
        end
        RESP: begin
          state_r     <= IDLE;
          req_ready_r <= 1'b1;
          busy_r      <= 1'b0;
        end
        default: begin
          state_r     <= IDLE;
          req_ready_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_r;
  assign busy       = busy_r;
  assign resp_valid = resp_valid_r;
  assign resp_err   = resp_err_r;
  assign read_data  = read_data_r;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: a 2-wait-state and a 0-wait-state responder against an array model.
`timescale 1ns/1ps
module tb_data_mem_responder;

  localparam int DW = 20;
  localparam int AW = 8;
  localparam int MS = 256;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          v2 = 1'b0, rd2 = 1'b0, wr2 = 1'b0, be2 = 1'b0;
  logic [AW-1:0] a2 = '0;
  logic [DW-1:0] wd2 = '0;
  logic          rdy2, rv2, err2, busy2;
  logic [DW-1:0] rdat2;

  logic          v0 = 1'b0, rd0 = 1'b0, wr0 = 1'b0, be0 = 1'b0;
  logic [AW-1:0] a0 = '0;
  logic [DW-1:0] wd0 = '0;
  logic          rdy0, rv0, err0, busy0;
  logic [DW-1:0] rdat0;

  data_mem_responder #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .MEM_SIZE(MS), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst), .req_valid(v2), .req_ready(rdy2), .MemRead(rd2), .MemWrite(wr2),
    .ByteEnable(be2), .address(a2), .write_data(wd2), .resp_valid(rv2), .read_data(rdat2),
    .resp_err(err2), .busy(busy2));

  data_mem_responder #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .MEM_SIZE(MS), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(v0), .req_ready(rdy0), .MemRead(rd0), .MemWrite(wr0),
    .ByteEnable(be0), .address(a0), .write_data(wd0), .resp_valid(rv0), .read_data(rdat0),
    .resp_err(err0), .busy(busy0));

  logic [DW-1:0] m2 [MS];
  logic [DW-1:0] m0 [MS];
  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic          e;
    logic [DW-1:0] d;
    int            acc;
  } exp_t;
  exp_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic f_ready(input bit s); return s ? rdy0 : rdy2; endfunction
  function automatic logic f_rv(input bit s); return s ? rv0 : rv2; endfunction
  function automatic logic f_err(input bit s); return s ? err0 : err2; endfunction
  function automatic logic f_busy(input bit s); return s ? busy0 : busy2; endfunction
  function automatic logic [DW-1:0] f_rdata(input bit s); return s ? rdat0 : rdat2; endfunction

  task automatic drive(input bit s, input logic v, input logic rd, input logic wr, input logic be,
                       input logic [AW-1:0] a, input logic [DW-1:0] wd);
    if (s) begin
      v0 = v; rd0 = rd; wr0 = wr; be0 = be; a0 = a; wd0 = wd;
    end else begin
      v2 = v; rd2 = rd; wr2 = wr; be2 = be; a2 = a; wd2 = wd;
    end
  endtask

  // Reference behaviour: errors and no-ops leave storage alone, byte ops touch value mod 256.
  task automatic model_apply(input bit s, input logic rd, input logic wr, input logic be,
                             input logic [AW-1:0] a, input logic [DW-1:0] wd,
                             output logic e, output logic [DW-1:0] d);
    logic [DW-1:0] cur;
    cur = s ? m0[a] : m2[a];
    e = (rd && wr) || (int'(a) >= MS);
    d = '0;
    if (!e && rd) begin
      d = be ? DW'(cur % 256) : cur;
    end else if (!e && wr) begin
      cur = be ? (cur - cur % 256) + DW'(wd % 256) : wd;
      if (s) m0[a] = cur; else m2[a] = cur;
    end
  endtask

  task automatic xact(input bit s, input logic rd, input logic wr, input logic be,
                      input logic [AW-1:0] a, input logic [DW-1:0] wd, input string tag,
                      output logic [DW-1:0] obs);
    logic e;
    logic [DW-1:0] d;
    int lat;
    int w;
    w = s ? 0 : 2;
    @(negedge clk);
    drive(s, 1'b1, rd, wr, be, a, wd);
    check({tag, ".ready"}, 32'(f_ready(s)), 32'd1);
    @(posedge clk);
    model_apply(s, rd, wr, be, a, wd, e, d);
    @(negedge clk);
    drive(s, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    check({tag, ".busy"}, 32'(f_busy(s)), 32'd1);
    check({tag, ".ready_low"}, 32'(f_ready(s)), 32'd0);
    lat = 1;
    while (f_rv(s) !== 1'b1 && lat < 16) begin
      @(negedge clk);
      lat++;
    end
    check({tag, ".latency"}, 32'(lat), 32'(w + 1));
    check({tag, ".err"}, 32'(f_err(s)), 32'(e));
    check({tag, ".data"}, 32'(f_rdata(s)), 32'(d));
    obs = f_rdata(s);
    @(negedge clk);
    check({tag, ".pulse"}, 32'(f_rv(s)), 32'd0);
    check({tag, ".ready_back"}, 32'(f_ready(s)), 32'd1);
    check({tag, ".hold"}, 32'(f_rdata(s)), 32'(d));
  endtask

  logic [AW-1:0] pool [8] = '{8'h10, 8'h20, 8'h30, 8'h41, 8'h52, 8'h63, 8'h7F, 8'hFF};

  task automatic pick(output logic rd, output logic wr, output logic be,
                      output logic [AW-1:0] a, output logic [DW-1:0] wd);
    int k;
    k  = $urandom_range(0, 7);
    rd = (k <= 2) || (k == 6);
    wr = (k >= 3 && k <= 6);
    be = 1'($urandom_range(0, 1));
    a  = pool[$urandom_range(0, 7)];
    wd = DW'($urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] obs;
    logic rd, wr, be, e, accepting;
    logic [AW-1:0] a;
    logic [DW-1:0] wd, d;
    int n_acc, last_acc;
    exp_t x;

    for (int i = 0; i < MS; i++) begin
      m2[i] = '0;
      m0[i] = '0;
    end

    repeat (2) @(negedge clk);
    check("rst.ready", 32'(rdy2), 32'd0);
    check("rst.rv", 32'(rv2), 32'd0);
    check("rst.err", 32'(err2), 32'd0);
    check("rst.busy", 32'(busy2), 32'd0);
    check("rst.rdata", 32'(rdat2), 32'd0);
    check("rst.ready0", 32'(rdy0), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("release.ready", 32'(rdy2), 32'd1);
    check("release.ready0", 32'(rdy0), 32'd1);

    xact(1'b0, 1'b0, 1'b1, 1'b0, 8'h10, 20'h5A5A5, "st_word", obs);
    xact(1'b0, 1'b1, 1'b0, 1'b0, 8'h10, 20'h00000, "ld_word", obs);
    check("ld_word.const", 32'(obs), 32'h5A5A5);

    xact(1'b0, 1'b0, 1'b1, 1'b0, 8'h10, 20'hFFFFF, "st_ones", obs);
    xact(1'b0, 1'b0, 1'b1, 1'b1, 8'h10, 20'hABC3C, "st_byte", obs);
    check("st_byte.zero", 32'(obs), 32'h00000);
    xact(1'b0, 1'b1, 1'b0, 1'b0, 8'h10, 20'h00000, "ld_merged", obs);
    check("ld_merged.const", 32'(obs), 32'hFFF3C);
    xact(1'b0, 1'b1, 1'b0, 1'b1, 8'h10, 20'h00000, "ld_byte", obs);
    check("ld_byte.const", 32'(obs), 32'h0003C);

    xact(1'b0, 1'b0, 1'b1, 1'b0, 8'h20, 20'h12345, "st_20", obs);
    xact(1'b0, 1'b1, 1'b1, 1'b0, 8'h20, 20'h00001, "both", obs);
    check("both.err_const", 32'(err2), 32'd1);
    check("both.data_const", 32'(obs), 32'h00000);
    xact(1'b0, 1'b1, 1'b0, 1'b0, 8'h20, 20'h00000, "ld_20", obs);
    check("ld_20.const", 32'(obs), 32'h12345);
    xact(1'b0, 1'b0, 1'b0, 1'b0, 8'h20, 20'h77777, "noop", obs);
    check("noop.err_const", 32'(err2), 32'd0);

    // Store interrupted by reset while waiting must never land.
    xact(1'b0, 1'b0, 1'b1, 1'b0, 8'h30, 20'h0ABCD, "st_30", obs);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h30, 20'h11111);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    check("midrst.busy_before", 32'(busy2), 32'd1);
    rst = 1'b0;
    #1;
    check("midrst.busy", 32'(busy2), 32'd0);
    check("midrst.rv", 32'(rv2), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("midrst.no_resp", 32'(rv2), 32'd0);
    end
    xact(1'b0, 1'b1, 1'b0, 1'b0, 8'h30, 20'h00000, "ld_30", obs);
    check("ld_30.const", 32'(obs), 32'h0ABCD);

    xact(1'b1, 1'b0, 1'b1, 1'b0, 8'h05, 20'h77777, "w0_st", obs);
    xact(1'b1, 1'b1, 1'b0, 1'b0, 8'h05, 20'h00000, "w0_ld", obs);
    check("w0_ld.const", 32'(obs), 32'h77777);
    xact(1'b1, 1'b1, 1'b0, 1'b1, 8'h05, 20'h00000, "w0_ldb", obs);
    check("w0_ldb.const", 32'(obs), 32'h00077);

    for (int i = 3; i < 8; i++) begin
      xact(1'b0, 1'b0, 1'b1, 1'b0, pool[i], DW'($urandom), "prefill", obs);
    end

    // Streaming: req_valid never drops; requests change only after acceptance.
    n_acc = 0;
    last_acc = -100;
    @(negedge clk);
    pick(rd, wr, be, a, wd);
    drive(1'b0, 1'b1, rd, wr, be, a, wd);
    for (int i = 0; i < 80; i++) begin
      if (rv2 === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("stream.spurious_resp", 32'd1, 32'(exp_q.size()));
        end else begin
          x = exp_q.pop_front();
          check("stream.latency", 32'(i - x.acc), 32'd3);
          check("stream.err", 32'(err2), 32'(x.e));
          check("stream.data", 32'(rdat2), 32'(x.d));
        end
      end
      if (busy2 === 1'b1) check("stream.ready_busy", 32'(rdy2), 32'd0);
      accepting = v2 && rdy2;
      @(posedge clk);
      if (accepting) begin
        model_apply(1'b0, rd, wr, be, a, wd, e, d);
        exp_q.push_back('{e: e, d: d, acc: i});
        if (n_acc > 0) check("stream.spacing", 32'(i - last_acc), 32'd4);
        last_acc = i;
        n_acc++;
      end
      @(negedge clk);
      if (accepting) begin
        pick(rd, wr, be, a, wd);
        drive(1'b0, 1'b1, rd, wr, be, a, wd);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    for (int i = 80; i < 90; i++) begin
      if (rv2 === 1'b1 && exp_q.size() > 0) begin
        x = exp_q.pop_front();
        check("drain.latency", 32'(i - x.acc), 32'd3);
        check("drain.err", 32'(err2), 32'(x.e));
        check("drain.data", 32'(rdat2), 32'(x.d));
      end
      @(negedge clk);
    end
    check("stream.accepts", 32'(n_acc), 32'd20);
    check("stream.lost", 32'(exp_q.size()), 32'd0);

    for (int i = 0; i < 8; i++) begin
      xact(1'b0, 1'b1, 1'b0, 1'b0, pool[i], 20'h00000, "final_ld", obs);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
